// File: rtl/dds_wave_ctrl_if.sv
// Host load stream for the DDS waveform sequencer.
// The host side (master) drives samples and the controller side (slave) returns ready.
interface dds_wave_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] ld_data;
  logic              ld_valid;
  logic              ld_ready;

  modport master (
    output ld_data,
    output ld_valid,
    input  ld_ready
  );

  modport slave (
    input  ld_data,
    input  ld_valid,
    output ld_ready
  );
endinterface

// File: rtl/dds_wave_ctrl.sv
// DDS waveform RAM sequencer: loads a table from the host stream, then plays it
// back through a phase accumulator with a fixed-latency read pipeline.
module dds_wave_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int RD_LAT = 2
) (
  input  logic              wr_clk,
  input  logic              tb_wr_rst,
  input  logic [ACC_W-1:0]  cfg_freq_word,
  input  logic [ADDR_W-1:0] cfg_phase_off,
  input  logic [ADDR_W:0]   cfg_load_len,
  input  logic              load_start,
  dds_wave_ctrl_if.slave    ld,
  output logic              load_done,
  input  logic              run_en,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] wave_out,
  output logic              wave_valid,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     r_len;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_load_done;

  logic [ACC_W-1:0]    r_acc;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_issue;
  logic [RD_LAT-1:0]   w_iss_vec;
  logic [DATA_W-1:0]   r_wave_out;
  logic                r_wave_valid;

  logic                w_ld_xfer;
  logic                w_load_last;
  logic                w_issue;
  logic                w_busy;
  logic                w_enter_load;
  logic                w_enter_run;

  // Busy covers the FSM and every sample still travelling through the read pipe.
  assign w_busy = (r_state != ST_IDLE) | r_issue | (|w_iss_vec) | r_wave_valid;

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ld_xfer    = 1'b0;
    w_load_last  = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          if (!w_busy) begin
            w_state_next = ST_LOAD;
          end
        end else if (run_en) begin
          w_state_next = ST_RUN;
        end
      end
      ST_LOAD: begin
        w_ld_xfer   = ld.ld_valid;
        w_load_last = ld.ld_valid && (r_cnt == (r_len - CNT_ONE));
        if (w_load_last) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (run_en) begin
          w_issue = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_enter_load = (r_state == ST_IDLE) && (w_state_next == ST_LOAD);
  assign w_enter_run  = (r_state == ST_IDLE) && (w_state_next == ST_RUN);

  // Load path: a length of zero selects the whole table.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      r_cnt       <= '0;
      r_len       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_wr_en     <= w_ld_xfer;
      r_load_done <= w_load_last;
      if (w_enter_load) begin
        r_cnt <= '0;
        r_len <= (cfg_load_len == '0) ? FULL_LEN : cfg_load_len;
      end else if (w_ld_xfer) begin
        r_wr_addr <= r_cnt[ADDR_W-1:0];
        r_wr_data <= ld.ld_data;
        r_cnt     <= r_cnt + CNT_ONE;
      end
    end
  end

  // Playback issue: both the accumulator and the offset add wrap silently.
  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      r_acc     <= '0;
      r_rd_addr <= '0;
      r_issue   <= 1'b0;
    end else begin
      r_issue <= w_issue;
      if (w_enter_run) begin
        r_acc <= '0;
      end else if (w_issue) begin
        r_rd_addr <= r_acc[ACC_W-1 -: ADDR_W] + cfg_phase_off;
        r_acc     <= r_acc + cfg_freq_word;
      end
    end
  end

  // Issue flag follows the RAM's address and output registers.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_lat
      logic r_stage;
      if (gi == 0) begin : g_first
        always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
          if (tb_wr_rst) begin
            r_stage <= 1'b0;
          end else begin
            r_stage <= r_issue;
          end
        end
      end else begin : g_next
        always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
          if (tb_wr_rst) begin
            r_stage <= 1'b0;
          end else begin
            r_stage <= w_iss_vec[gi-1];
          end
        end
      end
      assign w_iss_vec[gi] = r_stage;
    end
  endgenerate

  always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
    if (tb_wr_rst) begin
      r_wave_out   <= '0;
      r_wave_valid <= 1'b0;
    end else begin
      r_wave_valid <= w_iss_vec[RD_LAT-1];
      if (w_iss_vec[RD_LAT-1]) begin
        r_wave_out <= ram_rd_data;
      end
    end
  end

  assign ld.ld_ready  = (r_state == ST_LOAD);
  assign load_done    = r_load_done;
  assign ram_wr_en    = r_wr_en;
  assign ram_wr_addr  = r_wr_addr;
  assign ram_wr_data  = r_wr_data;
  assign ram_rd_addr  = r_rd_addr;
  assign wave_out     = r_wave_out;
  assign wave_valid   = r_wave_valid;
  assign busy         = w_busy;

endmodule

// File: doc/dds_wave_ctrl.md
Name: dds_wave_ctrl

Overview:
Sequencer for the DDS waveform RAM (14-bit address, 8-bit sample, simple dual-port, output register enabled, 2-cycle read latency). It loads a waveform into the RAM from a host valid/ready stream, then plays it back through a 32-bit phase accumulator. It drives the RAM write and read ports and presents registered samples to the DAC path. Both RAM ports run on the same clock.

Parameters:
ADDR_W, 14, RAM address width; table depth 2^ADDR_W
DATA_W, 8, sample width
ACC_W, 32, phase accumulator width; read address = acc[ACC_W-1 -: ADDR_W]
RD_LAT, 2, RAM read latency in cycles (address register plus output register)

Ports:
wr_clk  in  1  system/DDS clock
tb_wr_rst  in  1  reset
cfg_freq_word  in  ACC_W  phase increment, sampled every RUN cycle
cfg_phase_off  in  ADDR_W  address offset added to the accumulator address
cfg_load_len  in  ADDR_W+1  samples per load; 0 means 2^ADDR_W
load_start  in  1  request a waveform load
ld_data  in  DATA_W  load sample
ld_valid  in  1  load sample valid
ld_ready  out  1  controller accepts a sample
load_done  out  1  one-cycle pulse after the last sample is written
run_en  in  1  level; playback while high
ram_wr_en  out  1  RAM write enable
ram_wr_addr  out  ADDR_W  RAM write address
ram_wr_data  out  DATA_W  RAM write data
ram_rd_addr  out  ADDR_W  RAM read address
ram_rd_data  in  DATA_W  RAM read data
wave_out  out  DATA_W  playback sample
wave_valid  out  1  wave_out is a new sample this cycle
busy  out  1  state != IDLE or read pipeline not drained

Behaviour:
- Reset is tb_wr_rst, asynchronous, active-high. All logic is clocked on the rising edge of wr_clk.
- Reset values: state IDLE, accumulator 0, load counter 0, pipeline flags 0, and every output 0.
- A reset mid-load abandons the load. No resume occurs, and RAM contents are undefined for the partial range.
- FSM states are IDLE=0, LOAD=1 and RUN=2.
- IDLE -> LOAD on load_start. load_start has priority over run_en when both are high.
- IDLE -> RUN when run_en=1 and load_start=0. Entering RUN clears the accumulator to 0.
- In LOAD, run_en and load_start are ignored. After the last write, LOAD -> IDLE.
- In RUN, RUN -> IDLE when run_en=0, sampled each edge. load_start is ignored in RUN.
- LOAD handshake:
  - ld_ready=1 in LOAD only. A transfer occurs when ld_valid and ld_ready are both 1.
  - Each transfer registers ram_wr_en=1, ram_wr_addr=cnt, ram_wr_data=ld_data, then cnt++. ram_wr_en=0 on cycles without a transfer.
  - Addresses start at 0. cfg_load_len is latched on LOAD entry.
  - On the transfer with cnt==len-1, ld_ready drops at the next edge and load_done pulses for 1 cycle, aligned with the final ram_wr_en.
- RUN pipeline (t0 = edge at which the state becomes RUN, acc=0):
  - Each RUN edge: ram_rd_addr <= acc[ACC_W-1 -: ADDR_W] + cfg_phase_off, mod 2^ADDR_W, with issue flag=1 and acc <= acc + cfg_freq_word, mod 2^ACC_W.
  - t1: ram_rd_addr = cfg_phase_off, issue=1.
  - The issue flag is delayed RD_LAT cycles, then one more cycle registers wave_out <= ram_rd_data with wave_valid=1.
  - First wave_valid is at t1+RD_LAT+1 = t4, carrying RAM[cfg_phase_off].
- Leaving RUN stops issue immediately. Samples already in flight still emerge, so wave_valid stays high for RD_LAT+1 more edges and busy stays 1 until the pipe is empty.
- wave_out holds its last value while wave_valid=0. ram_rd_addr holds when not issuing.
- A new load_start is accepted only when busy=0.
- Wrap-around: the accumulator and the address add both wrap silently. A negative step (two's complement freq word) plays the table backward.

Test Plan:
- Load, cfg_load_len=16, data 0x10..0x1F, ld_valid continuous -> 16 writes to addr 0..15, ld_ready high 16 cycles, load_done at write 15, back to IDLE.
- Backpressure: ld_valid toggles 1,0,1,0 over 8 samples -> writes only on valid cycles, addresses contiguous 0..7, ram_wr_en=0 on gap cycles.
- Playback after load, freq_word=0x0004_0000, phase_off=0 -> first wave_valid 4 cycles after RUN entry; wave_out = 0x10,0x11,0x12,... one per cycle.
- Half-rate and offset playback:
  - freq_word=0x0002_0000 -> each sample repeated twice.
  - phase_off=3 -> sequence starts at 0x13.
  - run_en deassert -> exactly 3 trailing valid samples, then busy=0.
- Backward wrap, freq_word=0xFFFC_0000 -> ram_rd_addr 0, 16383, 16382, ...; cfg_load_len=0 -> 16384 writes, last addr 0x3FFF.
- Priority and reset:
  - load_start and run_en high together in IDLE -> LOAD entered.
  - tb_wr_rst pulsed after 5 load transfers -> all outputs 0 immediately, state IDLE, no load_done.
